note_sequencer: RTL and testbench

Keypad-to-voice controller placed between the 15-key pad input and the synth oscillator/waveform datapath. It synchronizes and debounces the pad and arbitrates simultaneous note keys with last-pressed priority. It also tracks the waveform-mode and octave toggles, then presents one registered note selection (index plus period divider) to the oscillator.

---
 rtl/synth_pkg.sv | 31 +++
 rtl/keypad_debounce.sv | 59 +++++
 rtl/note_sequencer.sv | 109 ++++++++++
 tb/tb_note_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the keypad-driven note sequencer.
// Divider values are oscillator periods in clk cycles at 10 MHz, C4 up to C5.
package synth_pkg;

   typedef enum logic [1:0] {
      SAW    = 2'd0,
      TRI    = 2'd1,
      SQUARE = 2'd2
   } mode_t;

   localparam int NUM_NOTES = 13;
   localparam int KEY_MODE  = 13;
   localparam int KEY_OCT   = 14;
   localparam int NUM_KEYS  = 15;

   localparam logic [15:0] DIV_TABLE [NUM_NOTES] = '{
      16'd38223, 16'd36077, 16'd34052, 16'd32141, 16'd30337, 16'd28635, 16'd27027,
      16'd25511, 16'd24079, 16'd22727, 16'd21452, 16'd20248, 16'd19111
   };

   // Index of the lowest set bit; 0 when nothing is set (callers check |v first).
   function automatic logic [3:0] lowest_set(input logic [NUM_NOTES-1:0] v);
      logic [3:0] r;
      r = '0;
      for (int i = NUM_NOTES - 1; i >= 0; i--) begin
         if (v[i]) r = 4'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Two-flop synchronizer plus one stability counter shared by all keys; the whole
// pad is accepted at once after DEBOUNCE_CYCLES edges without any s2 change.
module keypad_debounce
   import synth_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int W               = NUM_KEYS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] keypad_i,
   output logic [W-1:0] deb_o,
   output logic [W-1:0] rise_o
);

   localparam logic [15:0] THRESH = 16'(DEBOUNCE_CYCLES);

   logic [W-1:0] s1_q;
   logic [W-1:0] s2_q;
   logic [W-1:0] deb_q;
   logic [W-1:0] deb_prev_q;
   logic [15:0]  cnt_q;
   logic [15:0]  cnt_d;

   // s1 is the value s2 takes at this edge, so s1 != s2 means s2 is about to change.
   always_comb begin
      cnt_d = cnt_q;
      if (s1_q != s2_q) begin
         cnt_d = '0;
      end else if (cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q       <= '0;
         s2_q       <= '0;
         cnt_q      <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
      end else begin
         s1_q       <= keypad_i;
         s2_q       <= s1_q;
         cnt_q      <= cnt_d;
         deb_prev_q <= deb_q;
         if (cnt_d >= THRESH) begin
            deb_q <= s2_q;
         end
      end
   end

   assign deb_o = deb_q;

   for (genvar gi = 0; gi < W; gi++) begin : g_rise
      assign rise_o[gi] = deb_q[gi] & ~deb_prev_q[gi];
   end

endmodule

// File: rtl/note_sequencer.sv
// Keypad-to-voice controller: last-pressed note arbitration, waveform mode cycling
// and octave toggle, presenting one registered note selection to the oscillator.
module note_sequencer
   import synth_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int DIV_W           = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [14:0]         keypad_i,
   output logic                note_valid_o,
   output logic [3:0]          note_idx_o,
   output logic [DIV_W-1:0]    divider_o,
   output logic [1:0]          mode_o,
   output logic                octave_o,
   output logic                note_change_o
);

   logic [NUM_KEYS-1:0]  deb_w;
   logic [NUM_KEYS-1:0]  rise_w;
   logic [NUM_NOTES-1:0] note_deb;
   logic [NUM_NOTES-1:0] note_rise;
   logic                 unused_deb_ctrl;

   logic             valid_q, valid_d;
   logic [3:0]       idx_q, idx_d;
   logic [DIV_W-1:0] div_q, div_d;
   mode_t            mode_q, mode_d;
   logic             oct_q, oct_d;
   logic             chg_q, chg_d;

   keypad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .W              (NUM_KEYS)
   ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .keypad_i(keypad_i),
      .deb_o   (deb_w),
      .rise_o  (rise_w)
   );

   assign note_deb        = deb_w[NUM_NOTES-1:0];
   assign note_rise       = rise_w[NUM_NOTES-1:0];
   assign unused_deb_ctrl = ^deb_w[NUM_KEYS-1:NUM_NOTES];

   always_comb begin
      valid_d = valid_q;
      idx_d   = idx_q;
      mode_d  = mode_q;
      oct_d   = oct_q;
      chg_d   = 1'b0;
      if (!en) begin
         valid_d = 1'b0;
      end else begin
         if (rise_w[KEY_MODE]) begin
            case (mode_q)
               SAW:     mode_d = TRI;
               TRI:     mode_d = SQUARE;
               default: mode_d = SAW;
            endcase
         end
         if (rise_w[KEY_OCT]) begin
            oct_d = ~oct_q;
         end
         // An invalid selection is treated like a released one, which is what
         // picks up a still-held key after en returns.
         if (|note_rise) begin
            valid_d = 1'b1;
            idx_d   = lowest_set(note_rise);
         end else if (!valid_q || !note_deb[idx_q]) begin
            valid_d = |note_deb;
            if (|note_deb) begin
               idx_d = lowest_set(note_deb);
            end
         end
         chg_d = valid_d && (!valid_q || (idx_d != idx_q) || (oct_d != oct_q));
      end
      div_d = valid_d ? DIV_W'(DIV_TABLE[idx_d] >> oct_d) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
         div_q   <= '0;
         mode_q  <= SAW;
         oct_q   <= 1'b0;
         chg_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         idx_q   <= idx_d;
         div_q   <= div_d;
         mode_q  <= mode_d;
         oct_q   <= oct_d;
         chg_q   <= chg_d;
      end
   end

   assign note_valid_o  = valid_q;
   assign note_idx_o    = idx_q;
   assign divider_o     = div_q;
   assign mode_o        = mode_q;
   assign octave_o      = oct_q;
   assign note_change_o = chg_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer with DEBOUNCE_CYCLES=4: every output change
// is popped from a queue of hand-computed {cycle, outputs} entries and compared.
module tb_note_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [14:0] keypad_i;
   logic        note_valid_o;
   logic [3:0]  note_idx_o;
   logic [15:0] divider_o;
   logic [1:0]  mode_o;
   logic        octave_o;
   logic        note_change_o;

   note_sequencer #(
      .DEBOUNCE_CYCLES(4),
      .DIV_W          (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .keypad_i     (keypad_i),
      .note_valid_o (note_valid_o),
      .note_idx_o   (note_idx_o),
      .divider_o    (divider_o),
      .mode_o       (mode_o),
      .octave_o     (octave_o),
      .note_change_o(note_change_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [24:0] val;
      string       name;
   } exp_t;

   exp_t        sb_q[$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic        mon_on = 1'b0;
   logic [24:0] last_val;

   // Key-to-output latency with DEBOUNCE_CYCLES=4, counted from the negedge where
   // keys are driven: edge c+1 samples, deb at c+6, outputs at c+7.
   localparam int LAT = 7;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [24:0] pack(input logic v, input logic [3:0] i, input logic [15:0] d,
                                        input logic [1:0] m, input logic o, input logic ch);
      return {v, i, d, m, o, ch};
   endfunction

   always @(negedge clk) begin
      logic [24:0] cur;
      exp_t        e;
      if (mon_on) begin
         cur = pack(note_valid_o, note_idx_o, divider_o, mode_o, octave_o, note_change_o);
         if (cur !== last_val) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_change cyc=%0d actual=%h required=no change", cyc, cur);
            end else begin
               e = sb_q.pop_front();
               if (e.val !== cur || e.cyc != cyc) begin
                  n_bad++;
                  $display("FAIL %s actual=%h@%0d required=%h@%0d", e.name, cur, cyc, e.val, e.cyc);
               end else begin
                  $display("ok   %s cyc=%0d out=%h", e.name, cyc, cur);
               end
            end
            last_val = cur;
         end
      end
   end

   task automatic push(input int c, input string nm, input logic v, input logic [3:0] i,
                       input logic [15:0] d, input logic [1:0] m, input logic o, input logic pulse);
      exp_t e;
      e.cyc  = c;
      e.val  = pack(v, i, d, m, o, pulse);
      e.name = nm;
      sb_q.push_back(e);
      if (pulse) begin
         e.cyc  = c + 1;
         e.val  = pack(v, i, d, m, o, 1'b0);
         e.name = {nm, "_end"};
         sb_q.push_back(e);
      end
   endtask

   // Drive keys, expect one output change LAT cycles later, then let it settle.
   task automatic keys_exp(input logic [14:0] k, input string nm, input logic v, input logic [3:0] i,
                           input logic [15:0] d, input logic [1:0] m, input logic o, input logic pulse);
      @(negedge clk);
      keypad_i = k;
      push(cyc + LAT, nm, v, i, d, m, o, pulse);
      repeat (12) @(negedge clk);
   endtask

   task automatic keys_quiet(input logic [14:0] k);
      @(negedge clk);
      keypad_i = k;
      repeat (12) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end else begin
         $display("ok   %s = %0d", nm, act);
      end
   endtask

   initial begin
      rst      = 1'b1;
      en       = 1'b1;
      keypad_i = 15'h0008;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 16'(note_valid_o), 16'd0);
      chk("rst_idx", 16'(note_idx_o), 16'd0);
      chk("rst_div", divider_o, 16'd0);
      chk("rst_mode", 16'(mode_o), 16'd0);
      chk("rst_oct", 16'(octave_o), 16'd0);
      chk("rst_chg", 16'(note_change_o), 16'd0);
      last_val = pack(note_valid_o, note_idx_o, divider_o, mode_o, octave_o, note_change_o);
      mon_on   = 1'b1;
      rst      = 1'b0;
      keypad_i = '0;
      repeat (12) @(negedge clk);

      // single note and release
      keys_exp(15'h0200, "note9", 1'b1, 4'd9, 16'd22727, 2'd0, 1'b0, 1'b1);
      keys_exp(15'h0000, "rel9", 1'b0, 4'd9, 16'd0, 2'd0, 1'b0, 1'b0);

      // priority: last pressed wins, fall back to held note on release
      keys_exp(15'h0001, "note0", 1'b1, 4'd0, 16'd38223, 2'd0, 1'b0, 1'b1);
      keys_exp(15'h1001, "note12_over0", 1'b1, 4'd12, 16'd19111, 2'd0, 1'b0, 1'b1);
      keys_exp(15'h0001, "back_to0", 1'b1, 4'd0, 16'd38223, 2'd0, 1'b0, 1'b1);

      // glitch on bit 5 shorter than the debounce window
      @(negedge clk);
      keypad_i = 15'h0021;
      repeat (3) @(negedge clk);
      keypad_i = 15'h0001;
      repeat (14) @(negedge clk);
      keys_exp(15'h0000, "rel0", 1'b0, 4'd0, 16'd0, 2'd0, 1'b0, 1'b0);

      // mode cycling
      keys_exp(15'h2000, "mode_tri", 1'b0, 4'd0, 16'd0, 2'd1, 1'b0, 1'b0);
      keys_quiet(15'h0000);
      keys_exp(15'h2000, "mode_sq", 1'b0, 4'd0, 16'd0, 2'd2, 1'b0, 1'b0);
      keys_quiet(15'h0000);
      keys_exp(15'h2000, "mode_saw", 1'b0, 4'd0, 16'd0, 2'd0, 1'b0, 1'b0);
      keys_quiet(15'h0000);

      // octave while holding bit 12, mode press while valid gives no pulse
      keys_exp(15'h1000, "note12", 1'b1, 4'd12, 16'd19111, 2'd0, 1'b0, 1'b1);
      keys_exp(15'h5000, "oct_up", 1'b1, 4'd12, 16'd9555, 2'd0, 1'b1, 1'b1);
      keys_quiet(15'h1000);
      keys_exp(15'h3000, "mode_held", 1'b1, 4'd12, 16'd9555, 2'd1, 1'b1, 1'b0);
      keys_quiet(15'h1000);
      keys_exp(15'h5000, "oct_down", 1'b1, 4'd12, 16'd19111, 2'd1, 1'b0, 1'b1);
      keys_quiet(15'h1000);
      keys_exp(15'h0000, "rel12", 1'b0, 4'd12, 16'd0, 2'd1, 1'b0, 1'b0);

      // enable handling
      keys_exp(15'h0010, "note4", 1'b1, 4'd4, 16'd30337, 2'd1, 1'b0, 1'b1);
      @(negedge clk);
      en = 1'b0;
      push(cyc + 1, "en_off", 1'b0, 4'd4, 16'd0, 2'd1, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      keys_quiet(15'h2010);
      keys_quiet(15'h0010);
      @(negedge clk);
      en = 1'b1;
      push(cyc + 1, "en_on", 1'b1, 4'd4, 16'd30337, 2'd1, 1'b0, 1'b1);
      repeat (6) @(negedge clk);

      // mode and note 2 rising together
      keys_exp(15'h2014, "mode_note2", 1'b1, 4'd2, 16'd34052, 2'd2, 1'b0, 1'b1);
      keys_exp(15'h0000, "rel_all", 1'b0, 4'd2, 16'd0, 2'd2, 1'b0, 1'b0);

      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL pending_expectations actual=%0d required=0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
